// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and defaults for the data-memory port arbiter.
//   - ADDR_W_DEF / DATA_W_DEF / MAX_WAIT_DEF : default geometry and starvation limit
//   - port_id_t : identifies which requester owns a command
//   - cmd_t     : the registered command driving the memory for one cycle
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_id_t;

    // Field widths follow the package defaults; the top level sizes its
    // selection signals from its own parameters, so overriding ADDR_W/DATA_W
    // away from the defaults requires changing these too.
    typedef struct packed {
        logic                  valid;
        port_id_t              owner;
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

    localparam cmd_t CMD_RESET = '{
        valid: 1'b0,
        owner: PORT_CPU,
        we:    1'b0,
        addr:  {ADDR_W_DEF{1'b0}},
        wdata: {DATA_W_DEF{1'b0}}
    };

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter_if
//   Bundles both requester ports and the memory-side bus of the arbiter.
//   Port N: reqN/weN/addrN/wdataN (requester -> arbiter),
//           gntN/ackN/rdataN      (arbiter -> requester).
//   Memory: mem_addr/mem_wr_en/mem_wdata (arbiter -> memory),
//           mem_rdata                    (memory -> arbiter).
//   slave  : arbiter view.  master : requesters + memory view.
// ----------------------------------------------------------------------------
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, ack0, rdata0,
        output gnt1, ack1, rdata1,
        output mem_addr, mem_wr_en, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, ack0, rdata0,
        input  gnt1, ack1, rdata1,
        input  mem_addr, mem_wr_en, mem_wdata
    );

endinterface

// File: rtl/dmem_arb_prio.sv
// ----------------------------------------------------------------------------
// dmem_arb_prio
//   Fixed-priority grant (port 0 first) with starvation escalation for port 1.
//   Ports: clk, rst (async, active-high), req0, req1 in; gnt0, gnt1 out
//   (combinational, at most one set, never without its request).
//   wait_cnt counts consecutive refused cycles of port 1; once it reaches
//   MAX_WAIT, port 1 outranks port 0 for one grant.
// ----------------------------------------------------------------------------
module dmem_arb_prio #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              gnt0_s;
    logic              gnt1_s;

    // Grant decision and refusal counter next-state
    always_comb begin
        gnt1_s     = req1 & (~req0 | (wait_cnt_q == WAIT_MAX));
        gnt0_s     = req0 & ~gnt1_s;
        wait_cnt_d = {WAIT_W{1'b0}};
        if (req1 && !gnt1_s) begin
            if (wait_cnt_q == WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_ONE;
            end
        end else begin
            wait_cnt_d = {WAIT_W{1'b0}};
        end
    end

    // Refusal counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= {WAIT_W{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign gnt0 = gnt0_s;
    assign gnt1 = gnt1_s;

endmodule

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares a single-port data memory between the CPU (port 0) and the
//   debug/DMA loader (port 1). One command is accepted per cycle, registered,
//   presented to the memory for one cycle (memory acts on negedge), and the
//   result is returned as a one-cycle ack plus rdata to the owning port.
//   Ports: clk, rst (async, active-high), bus (dmem_port_arbiter_if.slave)
//   carrying both requester ports and the memory bus.
// ----------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus
);
    logic              gnt0_s;
    logic              gnt1_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_we_s;

    cmd_t              cmd_q;
    cmd_t              cmd_d;
    logic              ack0_q;
    logic              ack0_d;
    logic              ack1_q;
    logic              ack1_d;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata0_d;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata1_d;

    dmem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk  (clk),
        .rst  (rst),
        .req0 (bus.req0),
        .req1 (bus.req1),
        .gnt0 (gnt0_s),
        .gnt1 (gnt1_s)
    );

    // Accept stage: capture the granted port's command; without a grant the
    // fields are held (less toggling on the memory bus) and only valid drops.
    always_comb begin
        sel_addr_s  = bus.addr0;
        sel_wdata_s = bus.wdata0;
        sel_we_s    = bus.we0;
        cmd_d       = cmd_q;
        cmd_d.valid = 1'b0;
        if (gnt1_s) begin
            sel_addr_s  = bus.addr1;
            sel_wdata_s = bus.wdata1;
            sel_we_s    = bus.we1;
            cmd_d.valid = 1'b1;
            cmd_d.owner = PORT_DBG;
            cmd_d.we    = sel_we_s;
            cmd_d.addr  = sel_addr_s;
            cmd_d.wdata = sel_wdata_s;
        end else if (gnt0_s) begin
            cmd_d.valid = 1'b1;
            cmd_d.owner = PORT_CPU;
            cmd_d.we    = sel_we_s;
            cmd_d.addr  = sel_addr_s;
            cmd_d.wdata = sel_wdata_s;
        end else begin
            cmd_d.valid = 1'b0;
        end
    end

    // Response stage: memory data is already registered by the memory at the
    // mid-cycle negedge, so it is captured directly for the owner only.
    always_comb begin
        ack0_d   = cmd_q.valid && (cmd_q.owner == PORT_CPU);
        ack1_d   = cmd_q.valid && (cmd_q.owner == PORT_DBG);
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (ack0_d) begin
            rdata0_d = bus.mem_rdata;
        end else begin
            rdata0_d = rdata0_q;
        end
        if (ack1_d) begin
            rdata1_d = bus.mem_rdata;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // Command and response registers; reset drops any in-flight command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q    <= CMD_RESET;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= {DATA_W{1'b0}};
            rdata1_q <= {DATA_W{1'b0}};
        end else begin
            cmd_q    <= cmd_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.gnt0      = gnt0_s;
    assign bus.gnt1      = gnt1_s;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.mem_wr_en = cmd_q.valid & cmd_q.we;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter with a behavioural negedge memory
//   and a reference memory model for the randomised section.
// ----------------------------------------------------------------------------
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    dmem_port_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MAX_WAIT (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int errors = 0;
    int checks = 0;

    // Behavioural single-port memory: write-first, output registered on negedge
    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 8'hFF;
        return 8'($urandom_range(0, 7));
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack0"},   {31'd0, bus.ack0},      32'd0);
        chk({tag, "_ack1"},   {31'd0, bus.ack1},      32'd0);
        chk({tag, "_rdata0"}, {24'd0, bus.rdata0},    32'd0);
        chk({tag, "_rdata1"}, {24'd0, bus.rdata1},    32'd0);
        chk({tag, "_maddr"},  {24'd0, bus.mem_addr},  32'd0);
        chk({tag, "_mwe"},    {31'd0, bus.mem_wr_en}, 32'd0);
        chk({tag, "_mwdata"}, {24'd0, bus.mem_wdata}, 32'd0);
    endtask

    logic       h0, h1, e0, e1;
    int         w_m;
    logic       pn_a0, pn_a1, pc_a0, pc_a1;
    logic [7:0] pn_d0, pn_d1, pc_d0, pc_d1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst = 1'b1;
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        set1(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        chk_idle_outputs("rst");
        chk("rst_gnt0", {31'd0, bus.gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, bus.gnt1}, 32'd0);
        rst = 1'b0;
        tick();

        // Port 0 write A5 -> 0x10, then read it back
        set0(1'b1, 1'b1, 8'h10, 8'hA5);
        #1 chk("t2_gnt0_wr", {31'd0, bus.gnt0}, 32'd1);
        tick();
        chk("t2_mwe",   {31'd0, bus.mem_wr_en}, 32'd1);
        chk("t2_maddr", {24'd0, bus.mem_addr},  32'h10);
        chk("t2_mwd",   {24'd0, bus.mem_wdata}, 32'hA5);
        chk("t2_ack0_early", {31'd0, bus.ack0}, 32'd0);
        set0(1'b1, 1'b0, 8'h10, 8'h00);
        #1 chk("t2_gnt0_rd", {31'd0, bus.gnt0}, 32'd1);
        tick();
        chk("t2_ack0_wr",   {31'd0, bus.ack0},      32'd1);
        chk("t2_rdata0_wr", {24'd0, bus.rdata0},    32'hA5);
        chk("t2_mwe_rd",    {31'd0, bus.mem_wr_en}, 32'd0);
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("t2_ack0_rd",   {31'd0, bus.ack0},   32'd1);
        chk("t2_rdata0_rd", {24'd0, bus.rdata0}, 32'hA5);
        tick();
        chk("t2_ack0_end",  {31'd0, bus.ack0},   32'd0);

        // Reset in the access cycle of a port 0 write to 0x20
        set0(1'b1, 1'b1, 8'h20, 8'h55);
        tick();
        chk("t1_mwe_pre", {31'd0, bus.mem_wr_en}, 32'd1);
        rst = 1'b1;
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        #1 chk_idle_outputs("t1_inrst");
        tick();
        rst = 1'b0;
        #1 chk_idle_outputs("t1_post");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_idle_mwe",  {31'd0, bus.mem_wr_en}, 32'd0);
            chk("t1_idle_ack0", {31'd0, bus.ack0},      32'd0);
        end
        set0(1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("t1_rd20_ack",   {31'd0, bus.ack0},   32'd1);
        chk("t1_rd20_rdata", {24'd0, bus.rdata0}, 32'h00);
        tick();

        // Both ports requesting continuously: 4 grants to port 0, then 1 to port 1
        set0(1'b1, 1'b0, 8'h01, 8'h00);
        set1(1'b1, 1'b0, 8'h02, 8'h00);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_gnt1", {31'd0, bus.gnt1}, (i % 5 == 4) ? 32'd1 : 32'd0);
            chk("t3_gnt0", {31'd0, bus.gnt0}, (i % 5 == 4) ? 32'd0 : 32'd1);
            tick();
            chk("t3_wait", 32'(u_dut.u_prio.wait_cnt_q), (i % 5 == 4) ? 32'd0 : 32'(i % 5 + 1));
        end
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        set1(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();

        // Port 1 writes 3C to 0xFF, port 0 reads 0xFF the next cycle
        set1(1'b1, 1'b1, 8'hFF, 8'h3C);
        #1 chk("t4_gnt1", {31'd0, bus.gnt1}, 32'd1);
        tick();
        set1(1'b0, 1'b0, 8'h00, 8'h00);
        set0(1'b1, 1'b0, 8'hFF, 8'h00);
        #1 chk("t4_gnt0", {31'd0, bus.gnt0}, 32'd1);
        tick();
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        chk("t4_ack1",   {31'd0, bus.ack1},   32'd1);
        chk("t4_ack0_a", {31'd0, bus.ack0},   32'd0);
        chk("t4_rdata1", {24'd0, bus.rdata1}, 32'h3C);
        tick();
        chk("t4_ack0_b", {31'd0, bus.ack0},   32'd1);
        chk("t4_ack1_b", {31'd0, bus.ack1},   32'd0);
        chk("t4_rdata0", {24'd0, bus.rdata0}, 32'h3C);
        tick();

        // Reset during the access cycle of a port 1 read
        set1(1'b1, 1'b0, 8'hFF, 8'h00);
        #1 chk("t5_gnt1", {31'd0, bus.gnt1}, 32'd1);
        tick();
        set1(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        #1 chk("t5_ack1_a", {31'd0, bus.ack1}, 32'd0);
        tick();
        chk("t5_ack1_b", {31'd0, bus.ack1}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t5_cmd_valid", {31'd0, u_dut.cmd_q.valid}, 32'd0);
        chk("t5_mwe",       {31'd0, bus.mem_wr_en},     32'd0);
        tick();
        chk("t5_ack1_c",  {31'd0, bus.ack1},   32'd0);
        chk("t5_rdata1",  {24'd0, bus.rdata1}, 32'h00);
        tick();

        // Randomised traffic against a reference memory
        ref_mem[8'h10] = 8'hA5;
        ref_mem[8'hFF] = 8'h3C;
        h0 = 1'b0; h1 = 1'b0; w_m = 0;
        pn_a0 = 1'b0; pn_a1 = 1'b0; pc_a0 = 1'b0; pc_a1 = 1'b0;
        pn_d0 = 8'h00; pn_d1 = 8'h00; pc_d0 = 8'h00; pc_d1 = 8'h00;
        for (int k = 0; k < 302; k++) begin
            chk("r_ack0", {31'd0, bus.ack0}, {31'd0, pc_a0});
            chk("r_ack1", {31'd0, bus.ack1}, {31'd0, pc_a1});
            if (pc_a0) chk("r_rdata0", {24'd0, bus.rdata0}, {24'd0, pc_d0});
            if (pc_a1) chk("r_rdata1", {24'd0, bus.rdata1}, {24'd0, pc_d1});
            pc_a0 = pn_a0; pc_d0 = pn_d0;
            pc_a1 = pn_a1; pc_d1 = pn_d1;
            if (k >= 300) begin
                set0(1'b0, 1'b0, 8'h00, 8'h00);
                set1(1'b0, 1'b0, 8'h00, 8'h00);
            end else begin
                if (!h0) set0($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                              rand_addr(), 8'($urandom_range(0, 255)));
                if (!h1) set1($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                              rand_addr(), 8'($urandom_range(0, 255)));
            end
            #1;
            e1 = bus.req1 && (!bus.req0 || w_m == 4);
            e0 = bus.req0 && !e1;
            chk("r_gnt0",   {31'd0, bus.gnt0}, {31'd0, e0});
            chk("r_gnt1",   {31'd0, bus.gnt1}, {31'd0, e1});
            chk("r_onehot", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
            pn_a0 = e0;
            pn_a1 = e1;
            if (e0) begin
                if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
                pn_d0 = ref_mem[bus.addr0];
            end
            if (e1) begin
                if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
                pn_d1 = ref_mem[bus.addr1];
            end
            if (bus.req1 && !e1) w_m = (w_m < 4) ? w_m + 1 : 4;
            else w_m = 0;
            h0 = bus.req0 && !e0;
            h1 = bus.req1 && !e1;
            tick();
        end
        chk("r_drain_ack0", {31'd0, bus.ack0}, {31'd0, pc_a0});
        chk("r_drain_ack1", {31'd0, bus.ack1}, {31'd0, pc_a1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
